// File: rtl/output_port_arbiter.sv
// Per-output-port wormhole switch arbiter: round-robin among head flits, packet-level lock,
// one-entry registered output stage with valid/ready handshake.
module output_port_arbiter #(
    parameter int unsigned NUM_IN = 5,
    parameter int unsigned FLIT_W = 64,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_IN-1:0]        in_valid,
    input  logic [NUM_IN*FLIT_W-1:0] in_flit,
    output logic [NUM_IN-1:0]        in_ready,
    output logic                     out_valid,
    output logic [FLIT_W-1:0]        out_flit,
    input  logic                     out_ready,
    output logic [NUM_IN-1:0]        grant,
    output logic                     locked,
    output logic [CNT_W-1:0]         pkt_count
);

    localparam int unsigned PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    typedef enum logic {StIdle, StLocked} state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic [PTR_W-1:0]    r_ptr;
    logic [NUM_IN-1:0]   r_grant;
    logic                r_out_valid;
    logic [FLIT_W-1:0]   r_out_flit;
    logic [CNT_W-1:0]    r_pkt_count;

    logic [NUM_IN-1:0]   w_cand;
    logic                w_any;
    logic [PTR_W-1:0]    w_winner;
    logic [PTR_W-1:0]    w_idx;
    int unsigned         w_sum;
    logic [NUM_IN-1:0]   w_win_oh;
    logic [FLIT_W-1:0]   w_own_flit;
    logic                w_own_valid;
    logic                w_own_tail;
    logic                w_space;
    logic                w_xfer;
    logic                w_arb;

    always_comb begin
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            w_cand[i] = in_valid[i] && (in_flit[i*FLIT_W +: 2] == 2'b11);
        end
    end

    // The pointer holds the last winner, so the scan starts just past it.
    always_comb begin
        w_any    = 1'b0;
        w_winner = r_ptr;
        w_sum    = 0;
        w_idx    = '0;
        for (int unsigned k = 1; k <= NUM_IN; k++) begin
            w_sum = 32'(r_ptr) + k;
            if (w_sum >= NUM_IN) begin
                w_sum = w_sum - NUM_IN;
            end
            w_idx = PTR_W'(w_sum);
            if (!w_any && w_cand[w_idx]) begin
                w_any    = 1'b1;
                w_winner = w_idx;
            end
        end
        w_win_oh = NUM_IN'(1) << w_winner;
    end

    // While locked the owner index is the pointer itself.
    always_comb begin
        w_own_flit  = '0;
        w_own_valid = 1'b0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (PTR_W'(i) == r_ptr) begin
                w_own_flit  = in_flit[i*FLIT_W +: FLIT_W];
                w_own_valid = in_valid[i];
            end
        end
    end

    assign w_own_tail = (w_own_flit[1:0] == 2'b10);
    assign w_space    = !r_out_valid || out_ready;
    assign w_xfer     = (r_state == StLocked) && w_own_valid && w_space;
    assign w_arb      = (r_state == StIdle) && w_any;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (w_any) w_state_next = StLocked;
            StLocked: if (w_xfer && w_own_tail) w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_comb begin
        in_ready = '0;
        if (r_state == StLocked) begin
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                if (PTR_W'(i) == r_ptr) begin
                    in_ready[i] = w_space;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr       <= PTR_W'(NUM_IN - 1);
            r_grant     <= '0;
            r_out_valid <= 1'b0;
            r_out_flit  <= '0;
            r_pkt_count <= '0;
        end else begin
            if (w_arb) begin
                r_grant <= w_win_oh;
                r_ptr   <= w_winner;
            end else if (w_xfer && w_own_tail) begin
                r_grant <= '0;
            end

            if (w_xfer) begin
                r_out_flit  <= w_own_flit;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_xfer && w_own_tail) begin
                r_pkt_count <= r_pkt_count + CNT_W'(1);
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_flit  = r_out_flit;
    assign grant     = r_grant;
    assign locked    = (r_state == StLocked);
    assign pkt_count = r_pkt_count;

endmodule

// File: doc/output_port_arbiter.md
Name: output_port_arbiter

Overview:
- Per-output-port switch arbiter for the mesh router: one instance per output direction (N, S, E, W, L).
- Shares its output among the NUM_IN input ports whose route computation selected this direction.
- Uses round-robin among head flits. Locks the output to the winner from head flit through tail flit (wormhole, packet-level).
- Drives a one-entry registered output stage with valid/ready handshake toward the link or local sink.

Parameters:
NUM_IN, 5, number of requesting input ports (index 0..4 = N,S,E,W,L)
FLIT_W, 64, flit width; flit[1:0] is the type field (11 head, 01 body, 10 tail)
CNT_W, 16, width of completed-packet counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  NUM_IN  input i presents a flit routed to this output
in_flit  input  NUM_IN*FLIT_W  packed flits; input i at [i*FLIT_W +: FLIT_W]
in_ready  output  NUM_IN  flit of input i accepted this cycle when in_valid[i] & in_ready[i]
out_valid  output  1  out_flit holds a valid flit
out_flit  output  FLIT_W  registered output flit
out_ready  input  1  downstream accepts out_flit this cycle
grant  output  NUM_IN  one-hot current owner; all zero when unlocked
locked  output  1  output reserved by a packet in flight
pkt_count  output  CNT_W  number of tail flits forwarded, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, active-high), all outputs and state zeroed:
  - out_valid=0, out_flit=0, grant=0, locked=0, pkt_count=0.
  - state=IDLE; rr pointer=NUM_IN-1, so input 0 has highest priority first.
  - Reset mid-packet discards the packet in progress and the output register content.
- in_ready is combinational from state, grant, out_valid and out_ready.
- space = !out_valid | out_ready.
- FSM with two states:
  - IDLE:
    - candidate[i] = in_valid[i] & (in_flit_i[1:0]==2'b11).
    - Winner = first candidate scanning indices ptr+1, ptr+2, ..., ptr+NUM_IN, mod NUM_IN.
    - If any candidate: next edge sets grant=onehot(winner), locked=1, ptr=winner, state=LOCKED.
    - in_ready=0 for all inputs in IDLE; arbitration costs exactly 1 cycle.
    - Valid non-head flits are ignored in IDLE: not acknowledged, no grant.
  - LOCKED (owner o):
    - in_ready[o] = space; in_ready of every other input = 0.
    - Transfer when in_valid[o] & in_ready[o]: out_flit<=in_flit_o, out_valid<=1.
    - If the transferred flit type is 10 (tail), same edge: state=IDLE, grant=0, locked=0, pkt_count<=pkt_count+1.
    - Type 01 or 00 is treated as body; type 11 (the head, or a stray head) is forwarded, lock kept.
    - Tail and the next arbitration do not overlap: the earliest next grant comes one edge after the tail transfer, since IDLE evaluates in the cycle after.
- Output register:
  - If out_valid & out_ready and no new transfer this cycle, out_valid<=0 (out_flit holds its value).
  - Transfer plus out_ready in the same cycle gives back-to-back throughput of 1 flit/cycle.
  - With out_ready=0 and out_valid=1, out_flit is held stable and the owner is stalled.
- Latency: head presented in cycle t (IDLE) -> grant in t+1 -> accepted in t+1 if space -> out_valid in t+2.
- Fairness:
  - The pointer updates only on grant, so a just-served input is lowest priority at the next arbitration.
  - Starvation bounded to NUM_IN-1 packets.
- Owner dropping in_valid mid-packet: the lock is held indefinitely until its tail arrives (no timeout).
- pkt_count at 2^CNT_W-1 plus a tail wraps to 0.

Test Plan:
- Single packet: input 2 sends head 0x...0003, body 0x...0001, tail 0x...0002 back-to-back, out_ready=1 -> grant=00100 one cycle after head valid; out_flit sequence matches on 3 consecutive cycles starting 2 cycles after head valid; locked falls on tail edge; pkt_count=1.
- Round-robin contention: inputs 0, 1, 4 each hold a 2-flit packet from reset -> grant order 0, 1, 4. Inputs 0 and 1 then re-request -> order 0 then 1; no input is granted twice while another waits.
- Backpressure: out_ready=0 during an owner's 4-flit packet for 3 cycles after the first flit -> out_valid=1 and out_flit frozen, in_ready[o]=0; on release, remaining flits emerge 1/cycle with none lost or duplicated.
- Lock isolation: input 3 locked mid-packet while input 0 presents a head -> in_ready[0]=0 until 3's tail transfers; grant=00001 on the following edge.
- Stray flits and reset: body flit valid on input 1 in IDLE -> no grant, in_ready=0. Assert reset mid-packet -> all outputs 0 immediately (async); after release, input 0 wins a simultaneous 0/4 head request.
- Counter wrap: force 2^CNT_W packets (CNT_W=4 build, 16 packets) -> pkt_count returns to 0.
